i2c_bus_conditioner: RTL and testbench
======================================

Name: i2c_bus_conditioner

Overview:
- Front-end stage that sits directly upstream of the I2C slave core and conditions the raw `scl`/`sda` pin levels.
- Synchronises both lines into the `clk` domain and rejects glitches shorter than a programmable stability window.
- Produces single-cycle SCL edge strobes and START/STOP condition strobes, a bus-busy flag, and a saturating count of rejected glitches for status/debug.

Parameters:
- SYNC_STAGES, 2, number of flip-flops in each pin synchroniser (min 2).
- FILT_CYCLES, 4, consecutive synchronised samples that must differ from the filtered level before it updates (min 1).
- CNT_W, 3, width of each filter counter; must hold FILT_CYCLES-1.

Ports:
- clk  in  1  system clock; only clock in the block.
- rst  in  1  synchronous, active-high reset.
- scl_in  in  1  raw SCL pin level (asynchronous).
- sda_in  in  1  raw SDA pin level (asynchronous).
- scl_f  out  1  synchronised, filtered SCL.
- sda_f  out  1  synchronised, filtered SDA.
- scl_rise  out  1  one-cycle pulse; scl_f went 0->1.
- scl_fall  out  1  one-cycle pulse; scl_f went 1->0.
- start_det  out  1  one-cycle pulse; START or repeated START.
- stop_det  out  1  one-cycle pulse; STOP.
- bus_busy  out  1  high between a START and the next STOP.
- glitch_cnt  out  8  saturating count of rejected glitches, both lines combined.

Behaviour:
- Reset is sampled on the rising edge of `clk`. While `rst`=1:
  - Synchroniser flops, `scl_f`, `sda_f` and their delayed copies go to 1.
  - Filter counters go to 0.
  - `scl_rise`, `scl_fall`, `start_det`, `stop_det`, `bus_busy` go to 0.
  - `glitch_cnt` goes to 0.
  - Reset asserted mid-transaction aborts everything the next cycle; no STOP pulse is generated.
- Synchroniser: a plain SYNC_STAGES-deep shift chain per line. The last stage is `s_sync`.
- Filter, per line, independent:
  - If `s_sync`==filtered: counter <= 0.
  - If `s_sync`!=filtered and counter < FILT_CYCLES-1: counter increments.
  - If `s_sync`!=filtered and counter == FILT_CYCLES-1: filtered <= `s_sync` and counter <= 0.
  - Glitch: `s_sync` returns equal to filtered while counter != 0. `glitch_cnt` increments by 1, saturating at 255.
  - If both lines reject a glitch in the same cycle, `glitch_cnt` increments by 2, still saturating at 255.
- Latency: a clean pin transition appears on the filtered output exactly SYNC_STAGES+FILT_CYCLES clock edges after the first edge that samples the new level. Defaults give 6 cycles.
- Edge and condition strobes are registered-aligned: each pulse is high in the same cycle the filtered output first shows its new value, computed against the previous-cycle filtered value.
  - `scl_rise` = `scl_f` & ~`scl_f_d`.
  - `scl_fall` = ~`scl_f` & `scl_f_d`.
  - `start_det`: `sda_f` falls (1->0) while `scl_f`=1 and `scl_f_d`=1.
  - `stop_det`: `sda_f` rises (0->1) while `scl_f`=1 and `scl_f_d`=1.
  - If SCL and SDA filtered values change in the same cycle, neither START nor STOP is reported. The SCL edge pulse is still reported.
- `bus_busy`: set to 1 on the cycle after `start_det`, cleared to 0 on the cycle after `stop_det`.
  - Repeated START while busy: `start_det` pulses, `bus_busy` stays 1.
  - STOP while idle: `stop_det` pulses, `bus_busy` stays 0.
- Post-reset with pins held low: the filtered lines fall after the latency above. If SDA settles first while SCL is still filtered high, a START is reported. This is intended and matches real bus behaviour.
- All outputs are registers or pure functions of registers. No combinational path from `scl_in`/`sda_in` to any output.

Test Plan:
- Reset, then `scl_in`=`sda_in`=1 for 20 cycles, then `sda_in` 1->0 at cycle 0 with SCL high -> `sda_f` falls and `start_det`=1 at cycle 6 (defaults); `bus_busy`=1 from cycle 7; no `scl_*` pulses.
- SDA low pulse of 3 cycles while SCL high -> `sda_f` stays 1; no `start_det`; `glitch_cnt` 0->1. Repeat 300 times -> `glitch_cnt`=255 and holds.
- Full byte-like sequence of START, 9 SCL clocks of 20 cycles each, STOP -> exactly 9 `scl_rise` and 9 `scl_fall`, 1 `start_det`, 1 `stop_det`; `bus_busy` 0 afterwards.
- Repeated START (SDA falls with SCL high while `bus_busy`=1) -> `start_det` pulse; `bus_busy` never drops.
- `scl_in` and `sda_in` toggle on the same clock edge from a stable state -> `scl_f`/`sda_f` change together; `scl_fall`=1; `start_det`=`stop_det`=0.
- Assert `rst` for 1 cycle while `bus_busy`=1 and a filter counter is mid-count -> next cycle all pulses 0, `bus_busy`=0, `glitch_cnt`=0, `scl_f`=`sda_f`=1; no `stop_det` pulse.

Source files
------------

// File: rtl/i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : i2c_bus_conditioner
//  Purpose  : Synchronises and de-glitches raw SCL/SDA, then derives SCL edge,
//             START/STOP strobes, bus-busy and a rejected-glitch counter.
//  Revision : 1.0 - initial release
// ============================================================================
module i2c_bus_conditioner #(
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 4,
    parameter int CNT_W       = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_f,
    output logic       sda_f,
    output logic       scl_rise,
    output logic       scl_fall,
    output logic       start_det,
    output logic       stop_det,
    output logic       bus_busy,
    output logic [7:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(FILT_CYCLES - 1);

    // Bit 0 carries SCL, bit 1 carries SDA through the per-line filters.
    logic [1:0] w_raw;
    logic [1:0] w_filt;
    logic [1:0] w_glitch;
    logic [1:0] r_filt_d;
    logic       r_busy;
    logic [7:0] r_gcnt;
    logic [8:0] w_gsum;

    assign w_raw = {sda_in, scl_in};

    for (genvar i = 0; i < 2; i++) begin : g_line
        logic [SYNC_STAGES-1:0] r_sync;
        logic [CNT_W-1:0]       r_cnt;
        logic                   r_filt;
        logic                   w_s;

        assign w_s = r_sync[SYNC_STAGES-1];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_sync <= '1;
                r_cnt  <= '0;
                r_filt <= 1'b1;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw[i]};
                if (w_s == r_filt) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_cnt_last) begin
                    r_filt <= w_s;
                    r_cnt  <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end

        // A run of differing samples that ends before acceptance is a glitch.
        assign w_glitch[i] = (w_s == r_filt) && (r_cnt != '0);
        assign w_filt[i]   = r_filt;
    end

    assign w_gsum = {1'b0, r_gcnt} + 9'(w_glitch[0]) + 9'(w_glitch[1]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_filt_d <= 2'b11;
            r_busy   <= 1'b0;
            r_gcnt   <= '0;
        end else begin
            r_filt_d <= w_filt;
            r_gcnt   <= w_gsum[8] ? 8'hFF : w_gsum[7:0];
            if (start_det) begin
                r_busy <= 1'b1;
            end else if (stop_det) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign scl_f      = w_filt[0];
    assign sda_f      = w_filt[1];
    assign scl_rise   = w_filt[0] & ~r_filt_d[0];
    assign scl_fall   = ~w_filt[0] & r_filt_d[0];
    // Requiring SCL high in both cycles suppresses conditions when SCL and SDA move together.
    assign start_det  = r_filt_d[1] & ~w_filt[1] & w_filt[0] & r_filt_d[0];
    assign stop_det   = ~r_filt_d[1] & w_filt[1] & w_filt[0] & r_filt_d[0];
    assign bus_busy   = r_busy;
    assign glitch_cnt = r_gcnt;

endmodule
`default_nettype wire

// File: tb/tb_i2c_bus_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_i2c_bus_conditioner
//  Purpose  : Directed and randomised checks of i2c_bus_conditioner against a
//             sliding-window reference model of the pin conditioning rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_bus_conditioner;

    localparam int SYNC = 2;
    localparam int FILT = 4;

    logic       clk    = 1'b0;
    logic       rst    = 1'b1;
    logic       scl_in = 1'b1;
    logic       sda_in = 1'b1;
    logic       scl_f, sda_f, scl_rise, scl_fall, start_det, stop_det, bus_busy;
    logic [7:0] glitch_cnt;

    i2c_bus_conditioner #(.SYNC_STAGES(SYNC), .FILT_CYCLES(FILT), .CNT_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .scl_in     (scl_in),
        .sda_in     (sda_in),
        .scl_f      (scl_f),
        .sda_f      (sda_f),
        .scl_rise   (scl_rise),
        .scl_fall   (scl_fall),
        .start_det  (start_det),
        .stop_det   (stop_det),
        .bus_busy   (bus_busy),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, req, $time);
        end
    endtask

    // Model: pins appear to the filter SYNC edges after sampling; a line flips
    // once the last FILT visible samples all oppose it.
    bit hist [2][SYNC];
    bit win  [2][FILT];
    bit m_f  [2];
    bit m_fd [2];
    bit m_busy;
    int m_gcnt;

    task automatic model_reset();
        for (int l = 0; l < 2; l++) begin
            for (int k = 0; k < SYNC; k++) hist[l][k] = 1'b1;
            for (int k = 0; k < FILT; k++) win[l][k] = 1'b1;
            m_f[l]  = 1'b1;
            m_fd[l] = 1'b1;
        end
        m_busy = 1'b0;
        m_gcnt = 0;
    endtask

    task automatic model_edge(input bit ps, input bit pd);
        bit st, sp, vis, prev, all_opp;
        bit nf [2];
        int g;
        g  = 0;
        st = m_fd[1] & ~m_f[1] & m_f[0] & m_fd[0];
        sp = ~m_fd[1] & m_f[1] & m_f[0] & m_fd[0];
        for (int l = 0; l < 2; l++) begin
            vis = hist[l][0];
            for (int k = 0; k < SYNC - 1; k++) hist[l][k] = hist[l][k+1];
            hist[l][SYNC-1] = (l == 0) ? ps : pd;
            prev = win[l][FILT-1];
            for (int k = 0; k < FILT - 1; k++) win[l][k] = win[l][k+1];
            win[l][FILT-1] = vis;
            if (vis == m_f[l] && prev != m_f[l]) g++;
            all_opp = 1'b1;
            for (int k = 0; k < FILT; k++) if (win[l][k] == m_f[l]) all_opp = 1'b0;
            nf[l] = all_opp ? ~m_f[l] : m_f[l];
        end
        for (int l = 0; l < 2; l++) begin
            m_fd[l] = m_f[l];
            m_f[l]  = nf[l];
        end
        if (st)      m_busy = 1'b1;
        else if (sp) m_busy = 1'b0;
        m_gcnt = (m_gcnt + g > 255) ? 255 : m_gcnt + g;
    endtask

    int  t_rise, t_fall, t_start, t_stop, busy_drop;
    bit  watch_busy = 1'b0;

    task automatic clear_tally();
        t_rise = 0; t_fall = 0; t_start = 0; t_stop = 0; busy_drop = 0;
    endtask

    task automatic tick(input bit s, input bit d);
        scl_in = s;
        sda_in = d;
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge(s, d);
        #1;
        check("scl_f",      scl_f,      m_f[0]);
        check("sda_f",      sda_f,      m_f[1]);
        check("scl_rise",   scl_rise,   m_f[0] & ~m_fd[0]);
        check("scl_fall",   scl_fall,   ~m_f[0] & m_fd[0]);
        check("start_det",  start_det,  m_fd[1] & ~m_f[1] & m_f[0] & m_fd[0]);
        check("stop_det",   stop_det,   ~m_fd[1] & m_f[1] & m_f[0] & m_fd[0]);
        check("bus_busy",   bus_busy,   m_busy);
        check("glitch_cnt", glitch_cnt, 8'(m_gcnt));
        t_rise  += int'(scl_rise);
        t_fall  += int'(scl_fall);
        t_start += int'(start_det);
        t_stop  += int'(stop_det);
        if (watch_busy && !bus_busy) busy_drop++;
    endtask

    task automatic hold(input bit s, input bit d, input int n);
        for (int i = 0; i < n; i++) tick(s, d);
    endtask

    initial begin
        bit cur_sda, nd, rs_s, rs_d;
        int rem_s, rem_d;

        rst = 1'b1;
        hold(1, 1, 2);
        rst = 1'b0;
        hold(1, 1, 20);

        // START with exact latency
        clear_tally();
        for (int i = 1; i <= 10; i++) begin
            tick(1, 0);
            if (i == 5) check("sda_f_before_lat", sda_f, 1);
            if (i == 6) begin
                check("start_at_lat", start_det, 1);
                check("sda_f_at_lat", sda_f, 0);
            end
            if (i == 7) check("busy_after_start", bus_busy, 1);
        end
        check("start_count", 8'(t_start), 1);
        check("scl_pulses_on_start", 8'(t_rise + t_fall), 0);
        hold(1, 1, 10);

        // Short SDA pulses are rejected and counted up to saturation
        clear_tally();
        hold(1, 0, 3);
        hold(1, 1, 6);
        check("glitch_first", glitch_cnt, 1);
        for (int i = 0; i < 299; i++) begin
            hold(1, 0, 3);
            hold(1, 1, 6);
        end
        check("glitch_sat", glitch_cnt, 255);
        check("glitch_no_start", 8'(t_start), 0);
        hold(1, 0, 3);
        hold(1, 1, 6);
        check("glitch_hold_sat", glitch_cnt, 255);

        // Byte-like transfer: START, 9 clocks, STOP
        clear_tally();
        hold(1, 0, 10);
        cur_sda = 1'b0;
        for (int b = 0; b < 9; b++) begin
            nd = (b == 8) ? 1'b0 : 1'($urandom_range(0, 1));
            hold(0, cur_sda, 5);
            hold(0, nd, 5);
            hold(1, nd, 10);
            cur_sda = nd;
        end
        hold(1, 1, 15);
        check("byte_rise", 8'(t_rise), 9);
        check("byte_fall", 8'(t_fall), 9);
        check("byte_start", 8'(t_start), 1);
        check("byte_stop", 8'(t_stop), 1);
        check("byte_idle", bus_busy, 0);

        // Repeated START keeps the bus busy
        clear_tally();
        hold(1, 0, 10);
        watch_busy = 1'b1;
        hold(0, 0, 5);
        hold(0, 1, 5);
        hold(1, 1, 10);
        hold(1, 0, 10);
        hold(0, 0, 10);
        hold(1, 0, 10);
        watch_busy = 1'b0;
        hold(1, 1, 10);
        check("rs_starts", 8'(t_start), 2);
        check("rs_busy_drop", 8'(busy_drop), 0);
        check("rs_stop", 8'(t_stop), 1);

        // Simultaneous SCL/SDA change reports no condition
        clear_tally();
        for (int i = 1; i <= 10; i++) begin
            tick(0, 0);
            if (i == 6) begin
                check("simul_scl_f", scl_f, 0);
                check("simul_sda_f", sda_f, 0);
                check("simul_fall", scl_fall, 1);
            end
        end
        hold(1, 1, 10);
        check("simul_start", 8'(t_start), 0);
        check("simul_stop", 8'(t_stop), 0);
        check("simul_rise", 8'(t_rise), 1);

        // Reset mid-transaction with a filter counter mid-count
        hold(1, 0, 10);
        hold(0, 0, 10);
        hold(0, 1, 4);
        check("pre_rst_busy", bus_busy, 1);
        rst = 1'b1;
        tick(0, 1);
        rst = 1'b0;
        check("rst_busy", bus_busy, 0);
        check("rst_gcnt", glitch_cnt, 0);
        check("rst_scl_f", scl_f, 1);
        check("rst_sda_f", sda_f, 1);
        clear_tally();
        hold(1, 1, 12);
        check("rst_no_stop", 8'(t_stop), 0);

        // Random pin activity, independent hold lengths per line
        rem_s = 0; rem_d = 0; rs_s = 1'b1; rs_d = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (rem_s == 0) begin rs_s = 1'($urandom_range(0, 1)); rem_s = $urandom_range(1, 8); end
            if (rem_d == 0) begin rs_d = 1'($urandom_range(0, 1)); rem_d = $urandom_range(1, 8); end
            rem_s--;
            rem_d--;
            tick(rs_s, rs_d);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
